linx_console_fifo_axil: RTL and testbench



---
 rtl/linx_console_fifo_axil.sv | 247 ++++++++++++++++++++++++
 tb/tb_linx_console_fifo_axil.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/linx_console_fifo_axil.sv
// Per-channel console byte FIFOs with drop counters, flush and irq, read out over AXI4-Lite.
// Optional build macro LINX_CONSOLE_TS_EN adds a 16-bit cycle stamp per byte in DATA[31:16].
module linx_console_fifo_axil #(
  parameter int NCH   = 2,
  parameter int DEPTH = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   ch_valid,
  input  logic [8*NCH-1:0] ch_byte,
  input  logic [11:0]      s_axi_awaddr,
  input  logic             s_axi_awvalid,
  output logic             s_axi_awready,
  input  logic [31:0]      s_axi_wdata,
  input  logic [3:0]       s_axi_wstrb,
  input  logic             s_axi_wvalid,
  output logic             s_axi_wready,
  output logic [1:0]       s_axi_bresp,
  output logic             s_axi_bvalid,
  input  logic             s_axi_bready,
  input  logic [11:0]      s_axi_araddr,
  input  logic             s_axi_arvalid,
  output logic             s_axi_arready,
  output logic [31:0]      s_axi_rdata,
  output logic [1:0]       s_axi_rresp,
  output logic             s_axi_rvalid,
  input  logic             s_axi_rready,
  output logic             irq,
  output logic [NCH-1:0]   nonempty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;

  // Handshakes: a beat transfers on a rising edge where valid && ready are both high.
  // awready/wready (together) and arready are one-cycle pulses raised only while no
  // response is pending; bvalid/rvalid rise on the accept edge and hold until ready.
  logic aw_rdy_q;
  logic ar_rdy_q;
  logic wr_fire;
  logic rd_fire;

  assign s_axi_awready = aw_rdy_q;
  assign s_axi_wready  = aw_rdy_q;
  assign s_axi_arready = ar_rdy_q;
  assign wr_fire = aw_rdy_q & s_axi_awvalid & s_axi_wvalid;
  assign rd_fire = ar_rdy_q & s_axi_arvalid;

  logic [7:0]    aw_slot;
  logic [7:0]    ar_slot;
  logic [1:0]    aw_reg;
  logic [1:0]    ar_reg;
  logic          aw_ok;
  logic          ar_ok;
  logic [CH_W-1:0] ar_idx;

  assign aw_slot = s_axi_awaddr[11:4];
  assign ar_slot = s_axi_araddr[11:4];
  assign aw_reg  = s_axi_awaddr[3:2];
  assign ar_reg  = s_axi_araddr[3:2];
  assign aw_ok   = ({24'd0, aw_slot} < NCH);
  assign ar_ok   = ({24'd0, ar_slot} < NCH);
  assign ar_idx  = ar_slot[CH_W-1:0];

  logic unused_bits;
  assign unused_bits = ^{s_axi_wstrb, s_axi_wdata[31:2], s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  logic [NCH*CNT_W-1:0] cnt_flat;
  logic [NCH*16-1:0]    drop_flat;
  logic [NCH*8-1:0]     head_flat;
  logic [NCH-1:0]       ovf_flat;
  logic [NCH-1:0]       irq_en_flat;

`ifdef LINX_CONSOLE_TS_EN
  logic [15:0]       ts_q;
  logic [NCH*16-1:0] head_ts_flat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 16'd1;
  end
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      drop_q;
    logic             ovf_q;
    logic             irq_en_q;
    logic             sel_w;
    logic             sel_r;
    logic             full;
    logic             pop;
    logic             push;
    logic             flush;
    logic             drop_ev;
    logic             drop_clr;

    assign sel_w    = wr_fire && aw_ok && (aw_slot == 8'(c));
    assign sel_r    = rd_fire && ar_ok && (ar_slot == 8'(c));
    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign pop      = sel_r && (ar_reg == 2'd0) && (cnt_q != '0);
    assign flush    = sel_w && (aw_reg == 2'd3) && s_axi_wdata[1];
    assign drop_clr = sel_w && (aw_reg == 2'd2);
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign push     = ch_valid[c] && (!full || pop) && !flush;
    assign drop_ev  = ch_valid[c] && full && !pop && !flush;

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= ch_byte[8*c +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop)      cnt_q <= cnt_q + 1'b1;
        else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      end
    end

    // A clear landing with a drop restarts the count at that drop.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        drop_q <= '0;
        ovf_q  <= 1'b0;
      end else if (drop_clr) begin
        drop_q <= drop_ev ? 16'd1 : 16'd0;
        ovf_q  <= drop_ev;
      end else if (drop_ev) begin
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        ovf_q <= 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                          irq_en_q <= 1'b0;
      else if (sel_w && aw_reg == 2'd3) irq_en_q <= s_axi_wdata[0];
    end

`ifdef LINX_CONSOLE_TS_EN
    logic [15:0] ts_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (push) ts_mem[wr_ptr_q] <= ts_q;
    end

    assign head_ts_flat[16*c +: 16] = ts_mem[rd_ptr_q];
`endif

    assign cnt_flat[CNT_W*c +: CNT_W] = cnt_q;
    assign drop_flat[16*c +: 16]      = drop_q;
    assign head_flat[8*c +: 8]        = mem[rd_ptr_q];
    assign ovf_flat[c]                = ovf_q;
    assign irq_en_flat[c]             = irq_en_q;
    assign nonempty[c]                = (cnt_q != '0);
  end

  logic [CNT_W-1:0] sel_cnt;
  logic [15:0]      sel_drop;
  logic [7:0]       sel_head;
  logic             sel_ovf;
  logic             sel_irq_en;
  logic [31:0]      rd_word;

  assign sel_cnt    = cnt_flat[ar_idx*CNT_W +: CNT_W];
  assign sel_drop   = drop_flat[ar_idx*16 +: 16];
  assign sel_head   = head_flat[ar_idx*8 +: 8];
  assign sel_ovf    = ovf_flat[ar_idx];
  assign sel_irq_en = irq_en_flat[ar_idx];

  always_comb begin
    rd_word = '0;
    if (ar_ok) begin
      case (ar_reg)
        2'd0: begin
          if (sel_cnt != '0) begin
            rd_word[7:0] = sel_head;
            rd_word[8]   = 1'b1;
`ifdef LINX_CONSOLE_TS_EN
            rd_word[31:16] = head_ts_flat[ar_idx*16 +: 16];
`endif
          end
        end
        2'd1: begin
          rd_word[CNT_W-1:0] = sel_cnt;
          rd_word[16]        = (sel_cnt == '0);
          rd_word[17]        = (sel_cnt == CNT_W'(DEPTH));
          rd_word[18]        = sel_ovf;
        end
        2'd2: rd_word[15:0] = sel_drop;
        default: rd_word[0] = sel_irq_en;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_rdy_q     <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= 2'b00;
    end else begin
      aw_rdy_q <= !aw_rdy_q && s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid;
      if (wr_fire) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= aw_ok ? 2'b00 : 2'b10;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_rdy_q     <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= 2'b00;
    end else begin
      ar_rdy_q <= !ar_rdy_q && s_axi_arvalid && !s_axi_rvalid;
      if (rd_fire) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_word;
        s_axi_rresp  <= ar_ok ? 2'b00 : 2'b10;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= |(irq_en_flat & nonempty);
  end

endmodule

// File: tb/tb_linx_console_fifo_axil.sv
// Directed bench for linx_console_fifo_axil (NCH=2, DEPTH=64); stamp checks when LINX_CONSOLE_TS_EN is set.
module tb_linx_console_fifo_axil;
  localparam int NCH   = 2;
  localparam int DEPTH = 64;

`ifdef LINX_CONSOLE_TS_EN
  localparam logic [31:0] DMASK = 32'h0000_FFFF;
`else
  localparam logic [31:0] DMASK = 32'hFFFF_FFFF;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   ch_valid;
  logic [8*NCH-1:0] ch_byte;
  logic [11:0]      s_axi_awaddr;
  logic             s_axi_awvalid;
  logic             s_axi_awready;
  logic [31:0]      s_axi_wdata;
  logic [3:0]       s_axi_wstrb;
  logic             s_axi_wvalid;
  logic             s_axi_wready;
  logic [1:0]       s_axi_bresp;
  logic             s_axi_bvalid;
  logic             s_axi_bready;
  logic [11:0]      s_axi_araddr;
  logic             s_axi_arvalid;
  logic             s_axi_arready;
  logic [31:0]      s_axi_rdata;
  logic [1:0]       s_axi_rresp;
  logic             s_axi_rvalid;
  logic             s_axi_rready;
  logic             irq;
  logic [NCH-1:0]   nonempty;

  linx_console_fifo_axil #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_byte(ch_byte),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .irq(irq), .nonempty(nonempty)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Drivers: every task is entered at a falling edge and returns at a falling edge.
  task automatic push(input int c, input logic [7:0] b);
    ch_valid[c] = 1'b1;
    ch_byte[8*c +: 8] = b;
    @(negedge clk);
    ch_valid[c] = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r,
                          input bit co_push = 1'b0, input logic [7:0] co_byte = 8'h00,
                          input int hold = 0, input logic [31:0] hold_exp = 32'h0);
    int n;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_axi_arready && n < 50);
    if (!s_axi_arready) chk("arready_timeout", {31'd0, s_axi_arready}, 32'd1);
    if (co_push) begin
      ch_valid[0]  = 1'b1;
      ch_byte[7:0] = co_byte;
    end
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    if (co_push) ch_valid[0] = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_axi_rvalid) chk("rvalid_timeout", {31'd0, s_axi_rvalid}, 32'd1);
    d = s_axi_rdata;
    r = s_axi_rresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_rvalid", {31'd0, s_axi_rvalid}, 32'd1);
      chk("hold_rdata", s_axi_rdata, hold_exp);
    end
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] wd, output logic [1:0] r,
                           input bit co_push = 1'b0, input logic [7:0] co_byte = 8'h00);
    int n;
    s_axi_awaddr  = a;
    s_axi_wdata   = wd;
    s_axi_wstrb   = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_axi_awready && n < 50);
    if (!s_axi_awready) chk("awready_timeout", {31'd0, s_axi_awready}, 32'd1);
    if (co_push) begin
      ch_valid[0]  = 1'b1;
      ch_byte[7:0] = co_byte;
    end
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    if (co_push) ch_valid[0] = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_axi_bvalid) chk("bvalid_timeout", {31'd0, s_axi_bvalid}, 32'd1);
    r = s_axi_bresp;
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  logic [31:0] d;
  logic [31:0] d2;
  logic [1:0]  r;

  initial begin
    rst = 1'b1;
    ch_valid = '0; ch_byte = '0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_nonempty", {30'd0, nonempty}, 32'd0);
    chk("rst_handshake", {27'd0, s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid}, 32'd0);
    chk("rst_rdata", s_axi_rdata, 32'd0);
    chk("rst_resp", {28'd0, s_axi_bresp, s_axi_rresp}, 32'd0);
    axi_read(12'h004, d, r);
    chk("rst_status0", d, 32'h0001_0000);
    chk("rst_status0_resp", {30'd0, r}, 32'd0);

    // Basic push / pop on ch1
    push(1, 8'h48);
    push(1, 8'h69);
    chk("ch1_nonempty", {30'd0, nonempty}, 32'd2);
    axi_read(12'h010, d, r);
    chk("ch1_pop0", d & DMASK, 32'h0000_0148);
    axi_read(12'h010, d, r);
    chk("ch1_pop1", d & DMASK, 32'h0000_0169);
    axi_read(12'h010, d, r);
    chk("ch1_pop_empty", d, 32'h0000_0000);
    axi_read(12'h014, d, r);
    chk("ch1_status_empty", d, 32'h0001_0000);
    chk("ch1_drained_nonempty", {30'd0, nonempty}, 32'd0);

    // Overflow: 70 bytes into a 64-deep FIFO
    for (int i = 0; i < 70; i++) push(0, 8'(i));
    axi_read(12'h004, d, r);
    chk("ovf_status", d, 32'h0006_0040);
    axi_read(12'h008, d, r);
    chk("ovf_drop", d, 32'd6);
    axi_write(12'h008, 32'h0, r);
    chk("drop_clr_resp", {30'd0, r}, 32'd0);
    axi_read(12'h008, d, r);
    chk("drop_cleared", d, 32'd0);
    axi_read(12'h004, d, r);
    chk("ovf_cleared_status", d, 32'h0002_0040);

    // Push and pop on the same edge while full
    axi_read(12'h000, d, r, 1'b1, 8'hAA);
    chk("full_pushpop_data", d & DMASK, 32'h0000_0100);
    axi_read(12'h004, d, r);
    chk("full_pushpop_status", d, 32'h0002_0040);
    axi_read(12'h008, d, r);
    chk("full_pushpop_drop", d, 32'd0);

    // Drop while full, then drop coinciding with a DROP clear
    push(0, 8'h11);
    axi_read(12'h008, d, r);
    chk("single_drop", d, 32'd1);
    axi_write(12'h008, 32'h0, r, 1'b1, 8'h22);
    axi_read(12'h008, d, r);
    chk("clear_vs_drop_drop", d, 32'd1);
    axi_read(12'h004, d, r);
    chk("clear_vs_drop_status", d, 32'h0006_0040);

    // Flush ch0: count goes to 0, DROP kept
    axi_write(12'h00C, 32'h2, r);
    axi_read(12'h004, d, r);
    chk("flush0_status", d & 32'h0003_FFFF, 32'h0001_0000);
    axi_read(12'h008, d, r);
    chk("flush0_drop_kept", d, 32'd1);
    chk("flush0_nonempty", {30'd0, nonempty}, 32'd0);

    // Interrupt on ch1
    push(1, 8'h55);
    axi_write(12'h01C, 32'h1, r);
    repeat (2) @(negedge clk);
    chk("irq_rise", {31'd0, irq}, 32'd1);
    axi_read(12'h01C, d, r);
    chk("ctrl1_read", d, 32'd1);
    axi_read(12'h010, d, r);
    chk("irq_drain_pop", d & DMASK, 32'h0000_0155);
    @(negedge clk);
    chk("irq_fall", {31'd0, irq}, 32'd0);
    push(1, 8'h01);
    push(1, 8'h02);
    axi_write(12'h01C, 32'h3, r);
    axi_read(12'h014, d, r);
    chk("flush1_status", d, 32'h0001_0000);
    axi_read(12'h01C, d, r);
    chk("ctrl1_flush_reads0", d, 32'd1);
    @(negedge clk);
    chk("flush1_irq", {31'd0, irq}, 32'd0);

    // Out-of-range accesses, with rready held off
    axi_read(12'h040, d, r, 1'b0, 8'h00, 5, 32'h0);
    chk("oor_read_resp", {30'd0, r}, 32'd2);
    chk("oor_read_data", d, 32'd0);
    axi_write(12'h040, 32'hFFFF_FFFF, r);
    chk("oor_write_resp", {30'd0, r}, 32'd2);
    axi_read(12'hFFC, d, r);
    chk("oor_top_resp", {30'd0, r}, 32'd2);

`ifdef LINX_CONSOLE_TS_EN
    // Stamps of bytes pushed ten cycles apart
    push(0, 8'hA1);
    repeat (9) @(negedge clk);
    push(0, 8'hA2);
    axi_read(12'h000, d, r);
    axi_read(12'h000, d2, r);
    chk("ts_pop0", d & DMASK, 32'h0000_01A1);
    chk("ts_pop1", d2 & DMASK, 32'h0000_01A2);
    chk("ts_delta", {16'd0, d2[31:16] - d[31:16]}, 32'd10);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
